// File: rtl/exc_mem_guard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : exc_mem_guard                                                |
// | Description : Memory-stage address-exception unit. Checks each M-stage     |
// |               load/store against NREG programmable address windows,        |
// |               raises AdEL/AdES (earlier exceptions keep priority), and     |
// |               registers the result into W with stall/flush handling.       |
// |               Also captures BadVAddr and counts generated faults.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module exc_mem_guard #(
    parameter int          NREG     = 8,
    parameter int          CNT_W    = 16,
    parameter logic [4:0]  EXC_NONE = 5'd31,
    parameter logic [4:0]  EXC_ADEL = 5'd4,
    parameter logic [4:0]  EXC_ADES = 5'd5,
    parameter logic [31:0] R0_BASE  = 32'h0000_0000,
    parameter logic [31:0] R0_LIMIT = 32'h0000_3000
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [4:0]       exc_in,
    input  wire logic [31:0]      addr,
    input  wire logic [3:0]       be,
    input  wire logic             is_load,
    input  wire logic             is_store,
    input  wire logic             stall,
    input  wire logic             flush,
    input  wire logic             cfg_we,
    input  wire logic [3:0]       cfg_idx,
    input  wire logic [31:0]      cfg_base,
    input  wire logic [31:0]      cfg_limit,
    input  wire logic [2:0]       cfg_attr,
    input  wire logic             cnt_clr,
    output logic [4:0]            exc_m,
    output logic [4:0]            exc_w,
    output logic [31:0]           badvaddr,
    output logic [CNT_W-1:0]      fault_cnt
);

    // Attribute bit positions inside a window's {valid, word_only, read_only}
    localparam int c_ATTR_VALID = 2;
    localparam int c_ATTR_WORD  = 1;
    localparam int c_ATTR_RO    = 0;

    // Per-window hit and attribute flags, one bit per window
    logic [NREG-1:0] w_win_hit;
    logic [NREG-1:0] w_win_word;
    logic [NREG-1:0] w_win_ro;

    // Window table: each window is its own register group so that window 0
    // can carry a non-zero reset value while the others reset to invalid.
    for (genvar i = 0; i < NREG; i++) begin : g_win
        localparam logic [31:0] c_rst_base  = (i == 0) ? R0_BASE  : 32'h0;
        localparam logic [31:0] c_rst_limit = (i == 0) ? R0_LIMIT : 32'h0;
        localparam logic [2:0]  c_rst_attr  = (i == 0) ? 3'b100   : 3'b000;

        logic [31:0] base_q;
        logic [31:0] limit_q;
        logic [2:0]  attr_q;
        logic        w_sel;

        // Index decode; indices at or beyond NREG match no window and are dropped
        assign w_sel = cfg_we && (cfg_idx == 4'(i));

        // Window register: all three fields update together on a write
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                base_q  <= c_rst_base;
                limit_q <= c_rst_limit;
                attr_q  <= c_rst_attr;
            end else if (w_sel) begin
                base_q  <= cfg_base;
                limit_q <= cfg_limit;
                attr_q  <= cfg_attr;
            end
        end

        // limit <= base can never satisfy both compares, so such a window is empty
        assign w_win_hit[i]  = attr_q[c_ATTR_VALID]
                             && (addr >= base_q)
                             && (addr <  limit_q);
        assign w_win_word[i] = attr_q[c_ATTR_WORD];
        assign w_win_ro[i]   = attr_q[c_ATTR_RO];
    end

    logic w_hit;
    logic w_sel_word;
    logic w_sel_ro;

    // Priority select: walk from the top so the lowest hitting index wins
    always_comb begin
        w_hit      = 1'b0;
        w_sel_word = 1'b0;
        w_sel_ro   = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (w_win_hit[i]) begin
                w_hit      = 1'b1;
                w_sel_word = w_win_word[i];
                w_sel_ro   = w_win_ro[i];
            end
        end
    end

    logic w_access;
    logic w_partial;
    logic w_fault;
    logic w_exc_pending;
    logic w_gen_fault;
    logic w_capture;

    // Fault classification; load+store together is treated as a store
    always_comb begin
        w_access      = is_load | is_store;
        w_partial     = (be != 4'b1111);
        w_fault       = w_access & (~w_hit
                                    | (w_sel_word & w_partial)
                                    | (is_store & w_sel_ro));
        w_exc_pending = (exc_in != EXC_NONE);
        w_gen_fault   = w_fault & ~w_exc_pending;
        // Only a fault actually advancing into W is recorded, so a stalled
        // instruction is captured once, on the cycle it finally moves on.
        w_capture     = w_gen_fault & ~stall & ~flush;
    end

    // M-stage exception code: an earlier-stage exception always wins
    always_comb begin
        exc_m = EXC_NONE;
        if (w_exc_pending) begin
            exc_m = exc_in;
        end else if (w_fault && is_store) begin
            exc_m = EXC_ADES;
        end else if (w_fault) begin
            exc_m = EXC_ADEL;
        end
    end

    logic [4:0]       exc_w_q,     exc_w_d;
    logic [31:0]      badvaddr_q,  badvaddr_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    // Next-state for the W register, BadVAddr and the saturating counter
    always_comb begin
        exc_w_d     = exc_w_q;
        badvaddr_d  = badvaddr_q;
        fault_cnt_d = fault_cnt_q;

        // Flush squashes W even when the pipe is stalled
        if (flush) begin
            exc_w_d = EXC_NONE;
        end else if (!stall) begin
            exc_w_d = exc_m;
        end

        if (w_capture) begin
            badvaddr_d = addr;
        end

        // A clear beats a same-cycle increment; all-ones is sticky
        if (cnt_clr) begin
            fault_cnt_d = '0;
        end else if (w_capture && !(&fault_cnt_q)) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    // W-stage state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_w_q     <= EXC_NONE;
            badvaddr_q  <= 32'h0;
            fault_cnt_q <= '0;
        end else begin
            exc_w_q     <= exc_w_d;
            badvaddr_q  <= badvaddr_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign exc_w     = exc_w_q;
    assign badvaddr  = badvaddr_q;
    assign fault_cnt = fault_cnt_q;

endmodule
`default_nettype wire

// File: doc/exc_mem_guard.md
Name: exc_mem_guard

Overview:
- Parametrised memory-stage address-exception unit for the MIPS pipeline.
- Checks each M-stage load/store against NREG runtime-programmable address windows. Per-window attributes: valid, word-only, read-only.
- Produces an AdEL/AdES exception code, with priority to any earlier-stage exception.
- Registers the result into W with stall/flush, captures BadVAddr and keeps a saturating fault counter.

Parameters:
- NREG, 8: number of address windows (1..16).
- CNT_W, 16: fault counter width.
- EXC_NONE, 5'd31: "no exception" ExcCode.
- EXC_ADEL, 5'd4: load address-error code.
- EXC_ADES, 5'd5: store address-error code.
- R0_BASE, 32'h0000_0000: window 0 base at reset.
- R0_LIMIT, 32'h0000_3000: window 0 limit (exclusive) at reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- exc_in  in  5  ExcCode arriving with the M-stage instruction.
- addr  in  32  M-stage data address.
- be  in  4  byte enables.
- is_load  in  1  M instruction is a load.
- is_store  in  1  M instruction is a store.
- stall  in  1  hold W-stage registers.
- flush  in  1  squash: W gets EXC_NONE.
- cfg_we  in  1  window write strobe.
- cfg_idx  in  4  window index.
- cfg_base  in  32  window base.
- cfg_limit  in  32  window limit (exclusive).
- cfg_attr  in  3  {valid, word_only, read_only}.
- cnt_clr  in  1  clear fault counter.
- exc_m  out  5  combinational M-stage result.
- exc_w  out  5  registered W-stage result.
- badvaddr  out  32  last faulting address.
- fault_cnt  out  CNT_W  saturating count of generated faults.

Behaviour:
- Reset state:
  - window 0 = {R0_BASE, R0_LIMIT, valid=1, word_only=0, read_only=0}.
  - windows 1..NREG-1: all fields 0 (invalid).
  - exc_w=EXC_NONE, badvaddr=0, fault_cnt=0.
- Hit test (unsigned): base <= addr < limit and valid. If several windows hit, the lowest index supplies the attributes.
- access = is_load | is_store. When both are high, treat as a store.
- fault = access & (no hit | (word_only & be!=4'b1111) | (is_store & read_only)).
- exc_m priority:
  - exc_in != EXC_NONE: pass exc_in; no new fault.
  - fault & is_store: EXC_ADES.
  - fault (load only): EXC_ADEL.
  - otherwise: EXC_NONE.
- gen_fault = fault & exc_in==EXC_NONE.
- W register, one-cycle latency, evaluated each clk edge:
  - flush=1: exc_w <= EXC_NONE, whatever stall is. Flush wins over stall.
  - else stall=1: hold exc_w.
  - else: exc_w <= exc_m.
- badvaddr: loads addr when gen_fault & !stall & !flush; otherwise holds. Stalled or flushed faults are not captured, so a held instruction is not double-captured.
- fault_cnt:
  - cnt_clr: reset to 0. This takes priority over an increment in the same cycle.
  - else +1 under the same qualifier as badvaddr.
  - saturates at all-ones; never wraps.
- Config writes:
  - cfg_we with cfg_idx < NREG writes all three fields at the clk edge. cfg_idx >= NREG is ignored.
  - The window check in the write cycle uses the old contents; the new window is effective next cycle.
  - limit <= base makes the window empty; no error is raised.
- reset_n low mid-operation: all state returns to reset values immediately. exc_m stays combinational from the inputs and the reset window table.

Test Plan:
- After reset, load addr=32'h0000_1000, be=1111 -> exc_m=31. Next cycle exc_w=31, fault_cnt=0.
- Load addr=32'h0000_4000, exc_in=31 -> exc_m=4. Next edge: exc_w=4, badvaddr=32'h0000_4000, fault_cnt=1.
- Write idx 2 = {32'h7F00, 32'h7F40, attr 3'b110}, then store addr=32'h7F10, be=0011 -> exc_m=5. The same store with be=1111 -> exc_m=31.
- Make window 3 read-only covering 32'h8000..8FFF: load at 32'h8004 -> 31; store at 32'h8004 -> 5. Same-cycle check while writing idx 3 -> the old window applies.
- exc_in=5'd12 with an out-of-range store -> exc_m=12, badvaddr unchanged, fault_cnt unchanged.
- Faulting load with stall=1 and flush=1 -> exc_w=31, no capture. With CNT_W=2: four faults -> fault_cnt=3. cnt_clr plus a fault in the same cycle -> 0. Assert reset_n mid-run -> all outputs at reset values immediately.
